// File: rtl/uart_rx_8n1.sv
// 8N1 UART receiver: 2-FF synchronized input, mid-bit sampling, and a registered
// byte/valid output with framing-error and line-break pulses.
module uart_rx_8n1 #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       uart_rxd,
    input  logic       uart_rx_en,
    output logic [7:0] uart_rx_data,
    output logic       uart_rx_valid,
    output logic       uart_rx_busy,
    output logic       uart_rx_frame_err,
    output logic       uart_rx_break
);
    localparam int HALF = CLKS_PER_BIT / 2;
    localparam int CW   = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] C_HALF = CW'(HALF - 1);
    localparam logic [CW-1:0] C_FULL = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_STOP, S_WAIT
    } state_t;

    state_t        r_state, w_next;
    logic [1:0]    r_sync;
    logic [CW-1:0] r_cnt;
    logic [2:0]    r_idx;
    logic [7:0]    r_shift;
    logic [7:0]    r_data;
    logic          r_valid, r_busy, r_ferr, r_brk;
    logic          w_rxs;
    logic          w_smp_start, w_smp_data, w_smp_stop, w_good, w_ferr, w_hold_cnt;

    assign w_rxs = r_sync[1];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_sync <= 2'b11;
        else          r_sync <= {r_sync[0], uart_rxd};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (uart_rx_en && !w_rxs) w_next = S_START;
            S_START: if (r_cnt == C_HALF) w_next = w_rxs ? S_IDLE : S_DATA;
            S_DATA:  if (r_cnt == C_FULL && r_idx == 3'd7) w_next = S_STOP;
            S_STOP:  if (r_cnt == C_FULL) w_next = w_rxs ? S_IDLE : S_WAIT;
            S_WAIT:  if (w_rxs) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_smp_start = (r_state == S_START) && (r_cnt == C_HALF);
        w_smp_data  = (r_state == S_DATA)  && (r_cnt == C_FULL);
        w_smp_stop  = (r_state == S_STOP)  && (r_cnt == C_FULL);
        w_good      = w_smp_stop && w_rxs;
        w_ferr      = w_smp_stop && !w_rxs;
        // counters only run inside the timed states and restart at every sample
        w_hold_cnt  = (r_state == S_IDLE) || (r_state == S_WAIT) || (w_next != r_state) ||
                      w_smp_start || w_smp_data || w_smp_stop;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt   <= '0;
            r_idx   <= '0;
            r_shift <= '0;
            r_data  <= '0;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_ferr  <= 1'b0;
            r_brk   <= 1'b0;
        end else begin
            r_cnt <= w_hold_cnt ? '0 : r_cnt + 1'b1;
            if (w_next != r_state) r_idx <= '0;
            else if (w_smp_data)   r_idx <= r_idx + 1'b1;
            if (w_smp_data) r_shift[r_idx] <= w_rxs;
            if (w_good)     r_data <= r_shift;
            r_valid <= w_good;
            r_ferr  <= w_ferr;
            r_brk   <= w_ferr && (r_shift == 8'h00);
            r_busy  <= (w_next != S_IDLE);
        end
    end

    assign uart_rx_data      = r_data;
    assign uart_rx_valid     = r_valid;
    assign uart_rx_busy      = r_busy;
    assign uart_rx_frame_err = r_ferr;
    assign uart_rx_break     = r_brk;
endmodule

// File: tb/tb_uart_rx_8n1.sv
// Directed bench for uart_rx_8n1: a timestamp-based frame model checked every cycle,
// plus literal expectations on event timing and data per scenario.
module tb_uart_rx_8n1;
    localparam int C    = 8;
    localparam int HALF = C / 2;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       uart_rxd = 1'b1;
    logic       uart_rx_en = 1'b1;
    logic [7:0] uart_rx_data;
    logic       uart_rx_valid, uart_rx_busy, uart_rx_frame_err, uart_rx_break;

    uart_rx_8n1 #(.CLKS_PER_BIT(C)) dut (
        .clk(clk), .reset_n(reset_n), .uart_rxd(uart_rxd), .uart_rx_en(uart_rx_en),
        .uart_rx_data(uart_rx_data), .uart_rx_valid(uart_rx_valid), .uart_rx_busy(uart_rx_busy),
        .uart_rx_frame_err(uart_rx_frame_err), .uart_rx_break(uart_rx_break)
    );

    always #5 clk = ~clk;

    int  ncmp = 0, nerr = 0;
    int  cyc = 0;
    bit  p [0:8191];
    int  m_state = 0, m_t0 = 0;
    logic [7:0] e_data = 8'h00;
    logic e_valid = 0, e_ferr = 0, e_brk = 0, e_busy = 0;
    int  ev_cyc[$], ev_kind[$];
    logic [7:0] ev_data[$];
    int  bcount = 0;
    int  last_f = 0;

    // p[c] is the line level captured at edge c; the receiver acts on p[c-2] at edge c.
    always @(posedge clk) begin
        logic s;
        logic [7:0] b;
        #1;
        cyc = cyc + 1;
        p[cyc] = reset_n ? uart_rxd : 1'b1;
        if (!reset_n) begin
            m_state = 0; e_data = 8'h00;
            e_valid = 0; e_ferr = 0; e_brk = 0; e_busy = 0;
        end else begin
            s = p[cyc-2];
            e_valid = 0; e_ferr = 0; e_brk = 0;
            case (m_state)
                0: if (uart_rx_en && !s) begin m_state = 1; m_t0 = cyc - 1; end
                1: begin
                    if ((cyc - 1 - m_t0) == HALF && s) m_state = 0;
                    else if ((cyc - 1 - m_t0) == HALF + 9*C) begin
                        for (int k = 0; k < 8; k++) b[k] = p[m_t0 + HALF + (k+1)*C - 1];
                        if (s) begin e_valid = 1; e_data = b; m_state = 0; end
                        else begin e_ferr = 1; e_brk = (b == 8'h00); m_state = 2; end
                    end
                end
                2: if (s) m_state = 0;
                default: m_state = 0;
            endcase
            e_busy = (m_state != 0);
        end
        ncmp++;
        if ({uart_rx_data, uart_rx_valid, uart_rx_frame_err, uart_rx_break, uart_rx_busy} !==
            {e_data, e_valid, e_ferr, e_brk, e_busy}) begin
            nerr++;
            $display("FAIL cycle %0d model: got data=%h v=%b fe=%b brk=%b busy=%b, want data=%h v=%b fe=%b brk=%b busy=%b",
                     cyc, uart_rx_data, uart_rx_valid, uart_rx_frame_err, uart_rx_break, uart_rx_busy,
                     e_data, e_valid, e_ferr, e_brk, e_busy);
        end
        if (uart_rx_busy) bcount++;
        if (uart_rx_valid || uart_rx_frame_err) begin
            ev_cyc.push_back(cyc);
            ev_kind.push_back(uart_rx_valid ? 1 : (uart_rx_break ? 3 : 2));
            ev_data.push_back(uart_rx_data);
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        ncmp++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d (0x%0h), want %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic drive(input logic v, input int n);
        repeat (n) begin @(negedge clk); uart_rxd = v; end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_v);
        @(negedge clk); uart_rxd = 1'b0; last_f = cyc + 1;
        drive(1'b0, C - 1);
        for (int k = 0; k < 8; k++) drive(b[k], C);
        drive(stop_v, C);
    endtask

    task automatic clear_log();
        ev_cyc.delete(); ev_kind.delete(); ev_data.delete(); bcount = 0;
    endtask

    initial begin
        int f1, f2;
        drive(1'b1, 4);
        @(negedge clk); reset_n = 1'b1;
        drive(1'b1, 10);

        // 1: single 0xA5 frame
        clear_log();
        send_byte(8'hA5, 1'b1); f1 = last_f;
        drive(1'b1, 10);
        chk("s1_count", ev_kind.size(), 1);
        if (ev_kind.size() >= 1) begin
            chk("s1_kind", ev_kind[0], 1);
            chk("s1_time", ev_cyc[0], f1 + 78);
            chk("s1_data", ev_data[0], 8'hA5);
        end

        // 2: back-to-back 0x00, 0xFF
        clear_log();
        send_byte(8'h00, 1'b1); f1 = last_f;
        send_byte(8'hFF, 1'b1); f2 = last_f;
        drive(1'b1, 10);
        chk("s2_gap_stim", f2 - f1, 80);
        chk("s2_count", ev_kind.size(), 2);
        if (ev_kind.size() >= 2) begin
            chk("s2_spacing", ev_cyc[1] - ev_cyc[0], 80);
            chk("s2_data0", ev_data[0], 8'h00);
            chk("s2_data1", ev_data[1], 8'hFF);
        end

        // 3: 3-cycle glitch
        clear_log();
        drive(1'b0, 3);
        drive(1'b1, 20);
        chk("s3_events", ev_kind.size(), 0);
        chk("s3_busy_cycles", bcount, HALF);
        chk("s3_data_held", uart_rx_data, 8'hFF);

        // 4: framing error then recovery
        clear_log();
        send_byte(8'hA5, 1'b1);
        send_byte(8'h3C, 1'b0); f1 = last_f;
        drive(1'b1, 12);
        send_byte(8'h5A, 1'b1);
        drive(1'b1, 10);
        chk("s4_count", ev_kind.size(), 3);
        if (ev_kind.size() >= 3) begin
            chk("s4_ferr_kind", ev_kind[1], 2);
            chk("s4_ferr_time", ev_cyc[1], f1 + 78);
            chk("s4_ferr_data", ev_data[1], 8'hA5);
            chk("s4_next_kind", ev_kind[2], 1);
            chk("s4_next_data", ev_data[2], 8'h5A);
        end

        // 5: line held low for 15 bit times
        clear_log();
        @(negedge clk); uart_rxd = 1'b0; f1 = cyc + 1;
        drive(1'b0, 15*C - 1);
        chk("s5_busy_low", uart_rx_busy, 1);
        drive(1'b1, 10);
        chk("s5_busy_after", uart_rx_busy, 0);
        chk("s5_count", ev_kind.size(), 1);
        if (ev_kind.size() >= 1) begin
            chk("s5_kind", ev_kind[0], 3);
            chk("s5_time", ev_cyc[0], f1 + 78);
        end

        // 6: reset mid-frame
        clear_log();
        @(negedge clk); uart_rxd = 1'b0;
        drive(1'b0, C - 1);
        drive(1'b1, 2*C);
        drive(1'b0, 4);
        @(negedge clk); reset_n = 1'b0; uart_rxd = 1'b1;
        drive(1'b1, 3);
        chk("s6_rst_data", uart_rx_data, 8'h00);
        chk("s6_rst_flags", {uart_rx_valid, uart_rx_frame_err, uart_rx_break, uart_rx_busy}, 0);
        @(negedge clk); reset_n = 1'b1;
        drive(1'b1, 10);
        send_byte(8'h81, 1'b1);
        drive(1'b1, 10);
        chk("s6_count", ev_kind.size(), 1);
        if (ev_kind.size() >= 1) begin
            chk("s6_kind", ev_kind[0], 1);
            chk("s6_data", ev_data[0], 8'h81);
        end

        // 7: receiver disabled while idle ignores a whole frame
        @(negedge clk); uart_rx_en = 1'b0;
        clear_log();
        send_byte(8'h42, 1'b1);
        drive(1'b1, 5);
        @(negedge clk); uart_rx_en = 1'b1;
        drive(1'b1, 10);
        chk("s7_events", ev_kind.size(), 0);
        chk("s7_busy", bcount, 0);
        chk("s7_data", uart_rx_data, 8'h81);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end
endmodule
